// File: rtl/ifetch_defs_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encodings,
// instruction/step constants and the fetch buffer entry layout.
package ifetch_defs;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_RUN  = 2'd1,
        IF_HALT = 2'd2
    } if_state_e;

    localparam int INST_W  = 32;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_buf.sv
// Two-entry in-order fetch buffer holding {pc, inst}; the head lives in a
// register so decode sees registered outputs. Flush overrides push and pop.
module ifetch_buf
    import ifetch_defs::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic         full_o,
    output logic         empty_o
);

    logic [1:0]   count_q, count_d;
    fetch_entry_t mem_q [2];
    fetch_entry_t mem_d [2];
    logic         push_ok;
    logic         pop_ok;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign head_o  = mem_q[0];

    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        mem_d   = mem_q;
        count_d = count_q;
        if (flush_i) begin
            count_d = 2'd0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) mem_d[0] = push_data_i;
                    else                 mem_d[1] = push_data_i;
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    mem_d[0] = mem_q[1];
                    count_d  = count_q - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new word lands behind whatever remains.
                    if (count_q == 2'd1) begin
                        mem_d[0] = push_data_i;
                    end else begin
                        mem_d[0] = mem_q[1];
                        mem_d[1] = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= 2'd0;
            // NOTE: storage is reset too, so the head reads as zero out of reset.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments only.
            count_q  <= count_d;
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
        end
    end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, addresses the ROM and feeds decode
// through ifetch_buf. Define IFETCH_PERF_EN to add fetch/redirect counters.
module inst_fetch_ctrl
    import ifetch_defs::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              halt_req,
    input  logic              redir_valid,
    input  logic [31:0]       redir_target,
    output logic [31:0]       rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [INST_W-1:0] if_inst,
    output logic [31:0]       if_pc,
    output logic              halted
`ifdef IFETCH_PERF_EN
   ,output logic [31:0]       perf_fetch,
    output logic [15:0]       perf_redir
`endif
);

    localparam logic [ADDR_W-1:0] PC_RESET = {RESET_PC[ADDR_W-1:2], 2'b00};
    localparam logic [ADDR_W-1:0] PC_INC   = ADDR_W'(PC_STEP);

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              restart;
    logic              redir_apply;
    logic              fire;
    logic              buf_pop;
    logic              buf_full;
    logic              buf_empty;
    fetch_entry_t      buf_head;
    fetch_entry_t      fetch_word;
    logic              unused_redir_bits;

    assign unused_redir_bits = ^{redir_target[31:ADDR_W], redir_target[1:0]};

    assign rom_addr   = 32'(pc_q);
    assign buf_pop    = if_valid & if_ready;
    assign fetch_word = '{pc: 32'(pc_q), inst: rom_inst};

    always_comb begin
        state_d     = state_q;
        restart     = 1'b0;
        redir_apply = 1'b0;
        fire        = 1'b0;
        case (state_q)
            IF_IDLE, IF_HALT: begin
                if (start) begin
                    state_d = IF_RUN;
                    restart = 1'b1;
                end
            end
            IF_RUN: begin
                if (start) begin
                    restart = 1'b1;
                end else if (redir_valid) begin
                    redir_apply = 1'b1;
                    if (halt_req) state_d = IF_HALT;
                end else begin
                    // A slot freed by this cycle's pop can be refilled in the same cycle.
                    fire = ~buf_full | buf_pop;
                    if (halt_req) state_d = IF_HALT;
                end
            end
            default: state_d = IF_IDLE;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (restart)          pc_d = PC_RESET;
        else if (redir_apply) pc_d = {redir_target[ADDR_W-1:2], 2'b00};
        else if (fire)        pc_d = pc_q + PC_INC;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IF_IDLE;
            pc_q    <= PC_RESET;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    ifetch_buf u_buf (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (restart | redir_apply),
        .push_i      (fire),
        .push_data_i (fetch_word),
        .pop_i       (buf_pop),
        .head_o      (buf_head),
        .full_o      (buf_full),
        .empty_o     (buf_empty)
    );

    assign if_valid = ~buf_empty;
    assign if_pc    = buf_head.pc;
    assign if_inst  = buf_head.inst;
    assign halted   = (state_q == IF_HALT) & buf_empty;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [15:0] perf_redir_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q <= '0;
            perf_redir_q <= '0;
        end else if (restart) begin
            perf_fetch_q <= '0;
            perf_redir_q <= '0;
        end else begin
            if (fire)        perf_fetch_q <= perf_fetch_q + 32'd1;
            if (redir_apply) perf_redir_q <= perf_redir_q + 16'd1;
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_redir = perf_redir_q;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: directed vector table, hand sequences
// for halt/reset corners, and a randomized run against a queue-based reference model.
module tb_inst_fetch_ctrl;
    import ifetch_defs::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        halt_req;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        halted;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [15:0] perf_redir;
`endif

    always #5 clk = ~clk;

    // ROM word k holds k+1.
    assign rom_inst = (rom_addr >> 2) + 32'd1;

    inst_fetch_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .halt_req     (halt_req),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .rom_addr     (rom_addr),
        .rom_inst     (rom_inst),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_inst      (if_inst),
        .if_pc        (if_pc),
        .halted       (halted)
`ifdef IFETCH_PERF_EN
       ,.perf_fetch   (perf_fetch),
        .perf_redir   (perf_redir)
`endif
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic        start;
        logic        halt;
        logic        redir;
        logic [31:0] target;
        logic        ready;
        int          cycles;
        logic        exp_valid;
        logic        chk_pc;
        logic [31:0] exp_pc;
    } vec_t;

    exp_t        sb[$];
    if_state_e   m_state;
    logic [31:0] m_pc;
    int unsigned m_fetch;
    int unsigned m_redir;
    int          errors = 0;
    int          checks = 0;
    vec_t        vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_state = IF_IDLE;
        m_pc    = 32'h0;
        m_fetch = 0;
        m_redir = 0;
    endtask

    // Reference behaviour for one clock edge given the inputs currently driven.
    task automatic model_step();
        bit   pop;
        bit   restart;
        exp_t e;
        pop     = (sb.size() != 0) && if_ready;
        restart = 1'b0;
        case (m_state)
            IF_RUN: begin
                if (start) begin
                    restart = 1'b1;
                end else if (redir_valid) begin
                    sb.delete();
                    m_pc = redir_target & 32'h0000_00FC;
                    m_redir++;
                    if (halt_req) m_state = IF_HALT;
                end else begin
                    if (pop) void'(sb.pop_front());
                    if (sb.size() < 2) begin
                        e.pc   = m_pc;
                        e.inst = (m_pc >> 2) + 32'd1;
                        sb.push_back(e);
                        m_pc = (m_pc + 32'd4) & 32'h0000_00FF;
                        m_fetch++;
                    end
                    if (halt_req) m_state = IF_HALT;
                end
            end
            default: begin
                if (start) begin
                    m_state = IF_RUN;
                    restart = 1'b1;
                end else if (pop) begin
                    void'(sb.pop_front());
                end
            end
        endcase
        if (restart) begin
            sb.delete();
            m_pc    = 32'h0;
            m_fetch = 0;
            m_redir = 0;
        end
    endtask

    // Compare outputs against the model, advance the model, then take one clock edge.
    task automatic cycle();
        check("rom_addr", rom_addr, m_pc);
        check("if_valid", 32'(if_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("if_pc", if_pc, sb[0].pc);
            check("if_inst", if_inst, sb[0].inst);
        end
        check("halted", 32'(halted), 32'(m_state == IF_HALT && sb.size() == 0));
`ifdef IFETCH_PERF_EN
        check("perf_fetch", perf_fetch, m_fetch);
        check("perf_redir", 32'(perf_redir), m_redir & 32'h0000_FFFF);
`endif
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_if_valid"}, 32'(if_valid), 32'd0);
        check({tag, "_if_inst"}, if_inst, 32'd0);
        check({tag, "_if_pc"}, if_pc, 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_rom_addr"}, rom_addr, 32'd0);
`ifdef IFETCH_PERF_EN
        check({tag, "_perf_fetch"}, perf_fetch, 32'd0);
        check({tag, "_perf_redir"}, 32'(perf_redir), 32'd0);
`endif
    endtask

    task automatic drive(input logic s, input logic h, input logic r, input logic [31:0] t,
                         input logic rdy);
        start        = s;
        halt_req     = h;
        redir_valid  = r;
        redir_target = t;
        if_ready     = rdy;
    endtask

    initial begin
        //           start halt redir target        ready cyc  valid chk  pc
        vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 1,  1'b0, 1'b1, 32'h00};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1,  1'b1, 1'b1, 32'h00};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 3,  1'b1, 1'b1, 32'h0C};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 5,  1'b1, 1'b1, 32'h0C};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 2,  1'b1, 1'b1, 32'h14};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0000_0123, 1'b1, 1,  1'b0, 1'b0, 32'h00};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1,  1'b1, 1'b1, 32'h20};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 55, 1'b1, 1'b1, 32'hFC};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 1,  1'b1, 1'b1, 32'h00};

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        model_reset();
        #12;
        check_reset_values("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed stream: start, steady flow, backpressure, redirect, wrap.
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].start, vecs[i].halt, vecs[i].redir, vecs[i].target, vecs[i].ready);
            repeat (vecs[i].cycles) cycle();
            check($sformatf("vec%0d_if_valid", i), 32'(if_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].chk_pc) check($sformatf("vec%0d_if_pc", i), if_pc, vecs[i].exp_pc);
        end

        // Halt with two words buffered: both drain, then halted with the PC frozen.
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (3) cycle();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        cycle();
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        repeat (5) cycle();
        check("halt_drained_halted", 32'(halted), 32'd1);
        // start wins over a held halt_req.
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle();
        check("restart_if_valid", 32'(if_valid), 32'd1);
        check("restart_if_pc", if_pc, 32'h0);

        // Redirect and halt in the same cycle: PC takes the target, then HALT.
        repeat (3) cycle();
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FF47, 1'b1);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle();
        check("redir_halt_rom_addr", rom_addr, 32'h44);
        check("redir_halt_halted", 32'(halted), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if_ready     = ($urandom_range(0, 3) != 0);
            redir_valid  = ($urandom_range(0, 11) == 0);
            redir_target = $urandom;
            halt_req     = ($urandom_range(0, 39) == 0);
            start        = !redir_valid && ($urandom_range(0, 24) == 0);
            cycle();
        end

        // Asynchronous reset in the middle of a running stream.
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (6) cycle();
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0080, 1'b1);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (4) cycle();
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("mid_reset");
        model_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        cycle();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (4) cycle();
        check("post_reset_if_pc", if_pc, 32'h0C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
